// File: rtl/halo_receiver.sv
// halo_receiver: buffers halo pixels from up to NEIGHBORS tile PPUs in per-link
// FIFOs and drains them round-robin into the local accumulator buffer.
module halo_receiver #(
    parameter int TILE_SIZE  = 128,
    parameter int NEIGHBORS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_WIDTH = 8,
    localparam int CW = $clog2(TILE_SIZE)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 exchange_start,
    input  logic [NEIGHBORS-1:0]                 neighbor_present,
    input  logic [NEIGHBORS-1:0][DATA_WIDTH-1:0] neighbor_input_value,
    input  logic [NEIGHBORS-1:0][CW-1:0]         neighbor_input_row,
    input  logic [NEIGHBORS-1:0][CW-1:0]         neighbor_input_column,
    input  logic [NEIGHBORS-1:0]                 neighbor_input_write_enable,
    input  logic [NEIGHBORS-1:0]                 neighbor_exchange_done,
    output logic [NEIGHBORS-1:0]                 neighbor_cts,
    output logic [CW-1:0]                        buffer_row_write,
    output logic [CW-1:0]                        buffer_column_write,
    output logic [DATA_WIDTH-1:0]                buffer_data_write,
    output logic                                 buffer_write_enable,
    input  logic                                 buffer_ready,
    output logic                                 exchange_complete,
    output logic                                 overflow_error
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int IW   = (NEIGHBORS > 1) ? $clog2(NEIGHBORS) : 1;
    localparam int EW   = DATA_WIDTH + 2 * CW;

    typedef enum logic [1:0] {IDLE, RECEIVE, DRAIN, COMPLETE} state_t;

    state_t               state, state_next;
    logic [NEIGHBORS-1:0] present_mask, present_next;
    logic [NEIGHBORS-1:0] done_seen, done_next;
    logic [NEIGHBORS-1:0] cts_next;
    logic [NEIGHBORS-1:0] push, pop, not_empty;
    logic [EW-1:0]        fifo_mem [NEIGHBORS][FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr [NEIGHBORS];
    logic [PW-1:0]        rd_ptr [NEIGHBORS];
    logic [CNTW-1:0]      count [NEIGHBORS];
    logic [CNTW-1:0]      count_next [NEIGHBORS];
    logic [IW-1:0]        rr_ptr, grant_idx, cand;
    logic                 grant_valid, out_free, drained;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The present mask is captured only at round start; absent links count as done.
    always_comb begin
        state_next   = state;
        present_next = present_mask;
        done_next    = done_seen;
        case (state)
            IDLE: begin
                if (exchange_start) begin
                    state_next   = RECEIVE;
                    present_next = neighbor_present;
                    done_next    = ~neighbor_present;
                end
            end
            RECEIVE: begin
                done_next = done_seen | neighbor_exchange_done;
                if (&done_next) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_next = COMPLETE;
                end
            end
            COMPLETE: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        exchange_complete = (state == COMPLETE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            present_mask <= '0;
            done_seen    <= '0;
        end else begin
            present_mask <= present_next;
            done_seen    <= done_next;
        end
    end

    // Round-robin search starting at rr_ptr; the output stage takes a new entry
    // whenever it is empty or its current entry is being consumed.
    always_comb begin
        push        = neighbor_input_write_enable & neighbor_cts;
        out_free    = !buffer_write_enable || buffer_ready;
        grant_valid = 1'b0;
        grant_idx   = rr_ptr;
        cand        = rr_ptr;
        pop         = '0;
        for (int i = 0; i < NEIGHBORS; i++) begin
            not_empty[i] = (count[i] != '0);
        end
        for (int k = 0; k < NEIGHBORS; k++) begin
            cand = IW'((int'(rr_ptr) + k) % NEIGHBORS);
            if (!grant_valid && not_empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        if (grant_valid && out_free) begin
            pop[grant_idx] = 1'b1;
        end
        drained = (not_empty == '0) && out_free;
    end

    always_comb begin
        cts_next = '0;
        for (int i = 0; i < NEIGHBORS; i++) begin
            count_next[i] = count[i] + CNTW'(push[i]) - CNTW'(pop[i]);
            cts_next[i]   = (state_next == RECEIVE) && present_next[i] && !done_next[i]
                            && (count_next[i] < CNTW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            neighbor_cts <= '0;
            rr_ptr       <= '0;
            for (int i = 0; i < NEIGHBORS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            neighbor_cts <= cts_next;
            if (grant_valid && out_free) begin
                rr_ptr <= (grant_idx == IW'(NEIGHBORS - 1)) ? '0 : grant_idx + IW'(1);
            end
            for (int i = 0; i < NEIGHBORS; i++) begin
                count[i] <= count_next[i];
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NEIGHBORS; i++) begin
            if (push[i]) begin
                fifo_mem[i][wr_ptr[i]] <= {neighbor_input_value[i], neighbor_input_row[i],
                                           neighbor_input_column[i]};
            end
        end
    end

    // Output registers hold their entry until the accumulator buffer accepts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            buffer_write_enable <= 1'b0;
            buffer_data_write   <= '0;
            buffer_row_write    <= '0;
            buffer_column_write <= '0;
        end else if (grant_valid && out_free) begin
            buffer_write_enable <= 1'b1;
            {buffer_data_write, buffer_row_write, buffer_column_write}
                <= fifo_mem[grant_idx][rd_ptr[grant_idx]];
        end else if (buffer_ready) begin
            buffer_write_enable <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_error <= 1'b0;
        end else if (|(neighbor_input_write_enable & ~neighbor_cts)) begin
            overflow_error <= 1'b1;
        end
    end

endmodule
